// File: rtl/ex_mem_skid_stage.sv
// Execute->memory pipeline register with a 2-entry valid/ready skid buffer.
// Branch conditions are resolved from the flags captured alongside the ALU result.
module ex_mem_skid_stage #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_ALUResult,
  input  logic                  in_zeroFlag,
  input  logic                  in_carryFlag,
  input  logic                  in_negativeFlag,
  input  logic                  in_overflowFlag,
  input  logic [DATA_W-1:0]     in_storeData,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_regWrite,
  input  logic                  in_memRead,
  input  logic                  in_memWrite,
  input  logic                  in_isBranch,
  input  logic [2:0]            in_funct3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_ALUResult,
  output logic [DATA_W-1:0]     out_storeData,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_regWrite,
  output logic                  out_memRead,
  output logic                  out_memWrite,
  output logic                  out_branchTaken
);

  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     sd;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  isBranch;
    logic [2:0]            funct3;
    logic                  z;
    logic                  c;
    logic                  n;
    logic                  v;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t r_state, w_state_next;
  entry_t r_head, r_skid, w_in_entry;
  logic   r_in_ready, r_out_valid;
  logic   w_accept, w_retire;
  logic   w_load_head_in, w_load_head_skid, w_load_skid;
  logic   w_taken;

  // Branches never write back or touch memory, so gate their controls on capture.
  always_comb begin
    w_in_entry.alu      = in_ALUResult;
    w_in_entry.sd       = in_storeData;
    w_in_entry.rd       = in_rd;
    w_in_entry.regWrite = in_regWrite & ~in_isBranch;
    w_in_entry.memRead  = in_memRead  & ~in_isBranch;
    w_in_entry.memWrite = in_memWrite & ~in_isBranch;
    w_in_entry.isBranch = in_isBranch;
    w_in_entry.funct3   = in_funct3;
    w_in_entry.z        = in_zeroFlag;
    w_in_entry.c        = in_carryFlag;
    w_in_entry.n        = in_negativeFlag;
    w_in_entry.v        = in_overflowFlag;
  end

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_retire = r_out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_next   = S_ONE;
            w_load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_retire) begin
            w_load_head_in = 1'b1;
          end else if (w_accept) begin
            w_state_next = S_FULL;
            w_load_skid  = 1'b1;
          end else if (w_retire) begin
            w_state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_retire) begin
            w_state_next     = S_ONE;
            w_load_head_skid = 1'b1;
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != S_FULL);
      r_out_valid <= (w_state_next != S_EMPTY);
      if (w_load_head_in) begin
        r_head <= w_in_entry;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  always_comb begin
    w_taken = 1'b0;
    if (r_head.isBranch) begin
      case (r_head.funct3)
        3'b000:  w_taken = r_head.z;
        3'b001:  w_taken = ~r_head.z;
        3'b100:  w_taken = r_head.n ^ r_head.v;
        3'b101:  w_taken = ~(r_head.n ^ r_head.v);
        3'b110:  w_taken = r_head.c;
        3'b111:  w_taken = ~r_head.c;
        default: w_taken = 1'b0;
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign out_ALUResult   = r_head.alu;
  assign out_storeData   = r_head.sd;
  assign out_rd          = r_head.rd;
  assign out_regWrite    = r_head.regWrite;
  assign out_memRead     = r_head.memRead;
  assign out_memWrite    = r_head.memWrite;
  assign out_branchTaken = w_taken;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Scoreboard bench for ex_mem_skid_stage: directed scenarios plus a long random run
// checked against a 2-deep queue model with branch outcomes from operand comparisons.
module tb_ex_mem_skid_stage;
  localparam int DW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_ALUResult, in_storeData, out_ALUResult, out_storeData;
  logic          in_zeroFlag, in_carryFlag, in_negativeFlag, in_overflowFlag;
  logic [RW-1:0] in_rd, out_rd;
  logic          in_regWrite, in_memRead, in_memWrite, in_isBranch;
  logic [2:0]    in_funct3;
  logic          out_regWrite, out_memRead, out_memWrite, out_branchTaken;

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ALUResult(in_ALUResult), .in_zeroFlag(in_zeroFlag), .in_carryFlag(in_carryFlag),
    .in_negativeFlag(in_negativeFlag), .in_overflowFlag(in_overflowFlag),
    .in_storeData(in_storeData), .in_rd(in_rd), .in_regWrite(in_regWrite),
    .in_memRead(in_memRead), .in_memWrite(in_memWrite), .in_isBranch(in_isBranch),
    .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ALUResult(out_ALUResult), .out_storeData(out_storeData), .out_rd(out_rd),
    .out_regWrite(out_regWrite), .out_memRead(out_memRead), .out_memWrite(out_memWrite),
    .out_branchTaken(out_branchTaken)
  );

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [RW-1:0] rd;
    logic          rw, mr, mw, tk;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] cur_a, cur_b;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Branch outcome from the source operands themselves, not from flags.
  function automatic exp_t model_entry();
    exp_t e;
    e.alu = in_ALUResult;
    e.sd  = in_storeData;
    e.rd  = in_rd;
    if (in_isBranch) begin
      e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
      case (in_funct3)
        3'b000:  e.tk = (cur_a == cur_b);
        3'b001:  e.tk = (cur_a != cur_b);
        3'b100:  e.tk = ($signed(cur_a) <  $signed(cur_b));
        3'b101:  e.tk = ($signed(cur_a) >= $signed(cur_b));
        3'b110:  e.tk = (cur_a <  cur_b);
        3'b111:  e.tk = (cur_a >= cur_b);
        default: e.tk = 1'b0;
      endcase
    end else begin
      e.rw = in_regWrite; e.mr = in_memRead; e.mw = in_memWrite; e.tk = 1'b0;
    end
    return e;
  endfunction

  // Reference occupancy: a queue of at most two entries.
  always @(posedge clk or posedge reset) begin
    bit ret, acc;
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      ret = out_ready && (sb_q.size() > 0);
      acc = in_valid && (sb_q.size() < 2);
      if (ret) sb_q.delete(0);
      if (acc) sb_q.push_back(model_entry());
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", out_valid, sb_q.size() > 0);
      check("in_ready", in_ready, sb_q.size() < 2);
      if (out_valid && sb_q.size() > 0)
        check("payload",
              {out_ALUResult, out_storeData, out_rd, out_regWrite, out_memRead, out_memWrite, out_branchTaken},
              {sb_q[0].alu, sb_q[0].sd, sb_q[0].rd, sb_q[0].rw, sb_q[0].mr, sb_q[0].mw, sb_q[0].tk});
    end
  end

  task automatic put_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic br,
                        input logic [2:0] f3, input logic [RW-1:0] rd,
                        input logic rw, input logic mr, input logic mw);
    logic [DW-1:0] res;
    cur_a = a;
    cur_b = b;
    if (br) begin
      res             = a - b;
      in_zeroFlag     = (res == '0);
      in_carryFlag    = (a < b);
      in_negativeFlag = res[DW-1];
      in_overflowFlag = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
    end else begin
      res             = a + b;
      in_zeroFlag     = 1'($urandom);
      in_carryFlag    = 1'($urandom);
      in_negativeFlag = 1'($urandom);
      in_overflowFlag = 1'($urandom);
    end
    in_ALUResult = res;
    in_storeData = b;
    in_isBranch  = br;
    in_funct3    = f3;
    in_rd        = rd;
    in_regWrite  = rw;
    in_memRead   = mr;
    in_memWrite  = mw;
  endtask

  task automatic simple(input logic [DW-1:0] v);
    put_op(v, '0, 1'b0, 3'b000, 5'd1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic br_check(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2:0] f3, input logic req);
    @(negedge clk);
    put_op(a, b, 1'b1, f3, 5'd0, 1'b1, 1'b1, 1'b1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("branch_taken", out_branchTaken, req);
    check("branch_gating", {out_regWrite, out_memRead, out_memWrite}, 3'b000);
  endtask

  task automatic fill_full();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; simple(64'h11);
    @(negedge clk); simple(64'h22);
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    put_op('0, '0, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_outputs",
          {out_ALUResult, out_storeData, out_rd, out_regWrite, out_memRead, out_memWrite, out_branchTaken}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Pass-through
    @(negedge clk);
    put_op(64'h2000, 64'h0121, 1'b0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pass_alu", out_ALUResult, 64'h2121);
    check("pass_rd", out_rd, 5'd5);
    check("pass_valid", out_valid, 1'b1);
    @(negedge clk);

    // Skid: C is held off while full, then A, B, C drain in order
    out_ready = 1'b0; in_valid = 1'b1; simple(64'h1);
    @(negedge clk); simple(64'h2);
    @(negedge clk); simple(64'h3);
    check("skid_in_ready_low", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Branches resolved from SUB flags
    br_check(64'h0, 64'h1, 3'b110, 1'b1);
    br_check(64'h0, 64'h1, 3'b101, 1'b0);
    br_check('1, '1, 3'b000, 1'b1);
    br_check(64'h8000_0000_0000_0000, 64'h0800_0000_0000_0000, 3'b100, 1'b1);
    br_check(64'h5, 64'h5, 3'b010, 1'b0);
    @(negedge clk);

    // Flush while full with a valid input: the input is dropped
    fill_full();
    in_valid = 1'b1; flush = 1'b1; simple(64'hDEAD);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset while full, observed before any clock edge
    fill_full();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        put_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
      else
        put_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 3'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
